// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared types and constants for the MII receive framer
package eth_pkg;

    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, DROP} rx_state_t;

    localparam logic [3:0] PREAMBLE_NIB = 4'h5;
    localparam logic [3:0] SFD_NIB      = 4'hD;

    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    // Register value left by a right-shifting CRC after data plus its own FCS
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    localparam int STATUS_W    = 5;
    localparam int ST_ALIGN    = 0;
    localparam int ST_RX_ERR   = 1;
    localparam int ST_TOO_LONG = 2;
    localparam int ST_RUNT     = 3;
    localparam int ST_FCS_BAD  = 4;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

endpackage

// File: rtl/mii_rx_framer_if.sv
// rtl/mii_rx_framer_if.sv - PHY nibble input, payload byte stream and frame status bundle
interface mii_rx_framer_if import eth_pkg::*; #(
    parameter int LEN_W = 11
);
    logic                rx_dv;
    logic [3:0]          rxd;
    logic                rx_err;
    logic                out_valid;
    logic [7:0]          out_data;
    logic                out_sof;
    logic                frame_done;
    logic [LEN_W-1:0]    frame_len;
    logic                frame_ok;
    logic [STATUS_W-1:0] status;

    modport master (
        input  rx_dv, rxd, rx_err,
        output out_valid, out_data, out_sof, frame_done, frame_len, frame_ok, status
    );

    modport slave (
        output rx_dv, rxd, rx_err,
        input  out_valid, out_data, out_sof, frame_done, frame_len, frame_ok, status
    );
endinterface

// File: rtl/crc32_byte.sv
// rtl/crc32_byte.sv - combinational reflected CRC-32 update by one byte
module crc32_byte
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);
    localparam logic [31:0] POLY_REFL = reflect32(CRC32_POLY);

    always_comb begin
        crc_out = crc_in ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            crc_out = crc_out[0] ? ((crc_out >> 1) ^ POLY_REFL) : (crc_out >> 1);
        end
    end
endmodule

// File: rtl/mii_rx_framer.sv
// rtl/mii_rx_framer.sv - MII RX preamble/SFD stripper, byte assembler and frame status
// Optional FCS check enabled by MII_RX_FCS_CHECK_EN.
module mii_rx_framer
    import eth_pkg::*;
#(
    parameter int MIN_PREAMBLE = 2,
    parameter int MAX_BYTES    = 1518,
    parameter int MIN_BYTES    = 64,
    parameter int LEN_W        = 11
) (
    input  logic              clk,
    input  logic              rstn,
    mii_rx_framer_if.master   bus
);
    localparam logic [3:0]       PRE_MIN = 4'(MIN_PREAMBLE);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_BYTES);
    localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_BYTES + 1);
    localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_BYTES);

    rx_state_t           state, state_nxt;
    logic [3:0]          pre_cnt;
    logic                phase;
    logic [3:0]          lo_nib;
    logic [LEN_W-1:0]    len;
    logic                first_byte, err_seen, too_long;
    logic                sfd_ok, byte_done, frame_end, emit, fcs_bad;
    logic [7:0]          byte_val;
    logic [STATUS_W-1:0] st_nxt;

    always_comb begin
        state_nxt = state;
        sfd_ok    = 1'b0;
        byte_done = 1'b0;
        frame_end = 1'b0;
        case (state)
            IDLE:
                if (bus.rx_dv) state_nxt = (bus.rxd == PREAMBLE_NIB) ? PREAMBLE : DROP;
            PREAMBLE:
                if (!bus.rx_dv) begin
                    state_nxt = IDLE;
                end else if (bus.rxd == SFD_NIB && pre_cnt >= PRE_MIN) begin
                    state_nxt = PAYLOAD;
                    sfd_ok    = 1'b1;
                end else if (bus.rxd != PREAMBLE_NIB) begin
                    state_nxt = DROP;
                end
            PAYLOAD:
                if (!bus.rx_dv) begin
                    state_nxt = IDLE;
                    frame_end = 1'b1;
                end else begin
                    byte_done = phase;
                end
            DROP:
                if (!bus.rx_dv) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign byte_val = {bus.rxd, lo_nib};
    // len still holds this byte's index, so bytes at index >= MAX_BYTES are suppressed
    assign emit     = byte_done && (len < LEN_MAX);

`ifdef MII_RX_FCS_CHECK_EN
    logic [31:0] crc, crc_upd;

    crc32_byte u_crc32_byte (
        .crc_in  (crc),
        .data    (byte_val),
        .crc_out (crc_upd)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)       crc <= '0;
        else if (sfd_ok) crc <= CRC32_INIT;
        else if (emit)   crc <= crc_upd;
    end

    assign fcs_bad = (crc != CRC32_RESIDUE) && !phase;
`else
    assign fcs_bad = 1'b0;
`endif

    always_comb begin
        st_nxt              = '0;
        st_nxt[ST_ALIGN]    = phase;
        st_nxt[ST_RX_ERR]   = err_seen;
        st_nxt[ST_TOO_LONG] = too_long;
        st_nxt[ST_RUNT]     = (len < LEN_MIN);
        st_nxt[ST_FCS_BAD]  = fcs_bad;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pre_cnt        <= '0;
            phase          <= 1'b0;
            lo_nib         <= '0;
            len            <= '0;
            first_byte     <= 1'b0;
            err_seen       <= 1'b0;
            too_long       <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.out_data   <= '0;
            bus.out_sof    <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.frame_len  <= '0;
            bus.frame_ok   <= 1'b0;
            bus.status     <= '0;
        end else begin
            bus.out_valid  <= emit;
            bus.out_sof    <= emit && first_byte;
            bus.frame_done <= frame_end;
            if (emit) bus.out_data <= byte_val;

            if (state == IDLE) begin
                pre_cnt <= 4'd1;
            end else if (state == PREAMBLE && bus.rxd == PREAMBLE_NIB && pre_cnt != 4'hF) begin
                pre_cnt <= pre_cnt + 4'd1;
            end

            if (sfd_ok) begin
                phase      <= 1'b0;
                len        <= '0;
                first_byte <= 1'b1;
                err_seen   <= 1'b0;
                too_long   <= 1'b0;
            end else if (state == PAYLOAD && bus.rx_dv) begin
                phase <= ~phase;
                if (!phase)      lo_nib   <= bus.rxd;
                if (bus.rx_err)  err_seen <= 1'b1;
                if (byte_done) begin
                    first_byte <= 1'b0;
                    if (len != LEN_SAT) len <= len + 1'b1;
                    if (len == LEN_MAX) too_long <= 1'b1;
                end
            end

            // Result registers change only here, so a following frame cannot disturb them
            if (frame_end) begin
                bus.frame_len <= len;
                bus.status    <= st_nxt;
                bus.frame_ok  <= ~|st_nxt;
            end
        end
    end
endmodule

// File: tb/tb_mii_rx_framer.sv
// tb/tb_mii_rx_framer.sv - directed self-checking bench for mii_rx_framer
module tb_mii_rx_framer;
    import eth_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    mii_rx_framer_if #(.LEN_W(11)) bus ();

    mii_rx_framer #(
        .MIN_PREAMBLE (2),
        .MAX_BYTES    (1518),
        .MIN_BYTES    (64),
        .LEN_W        (11)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

`ifdef MII_RX_FCS_CHECK_EN
    localparam logic FCS_BIT = 1'b1;
`else
    localparam logic FCS_BIT = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    logic [7:0]  tx_mem [0:2047];
    logic [7:0]  got_data [$];
    logic        got_sof  [$];
    logic [10:0] done_len [$];
    logic [4:0]  done_st  [$];
    logic        done_ok  [$];

    always @(negedge clk) begin
        if (bus.out_valid) begin
            got_data.push_back(bus.out_data);
            got_sof.push_back(bus.out_sof);
        end
        if (bus.frame_done) begin
            done_len.push_back(bus.frame_len);
            done_st.push_back(bus.status);
            done_ok.push_back(bus.frame_ok);
        end
    end

    task automatic drive(input logic dv, input logic [3:0] nib, input logic err);
        @(negedge clk);
        bus.rx_dv  = dv;
        bus.rxd    = nib;
        bus.rx_err = err;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 4'h0, 1'b0);
    endtask

    task automatic fill_default();
        for (int i = 0; i < 2048; i++) tx_mem[i] = 8'(i);
    endtask

    task automatic clear_mon();
        got_data.delete(); got_sof.delete();
        done_len.delete(); done_st.delete(); done_ok.delete();
    endtask

    task automatic send_frame(input int npre, input int nbytes, input logic extra, input int err_idx);
        for (int i = 0; i < npre; i++) drive(1'b1, PREAMBLE_NIB, 1'b0);
        drive(1'b1, SFD_NIB, 1'b0);
        for (int b = 0; b < nbytes; b++) begin
            drive(1'b1, tx_mem[b][3:0], b == err_idx);
            drive(1'b1, tx_mem[b][7:4], b == err_idx);
        end
        if (extra) drive(1'b1, 4'h7, 1'b0);
        drive(1'b0, 4'h0, 1'b0);
    endtask

    task automatic test_reset();
        bus.rx_dv = 1'b0; bus.rxd = 4'h0; bus.rx_err = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.out_sof, bus.out_data} !== 10'd0) begin
            failures++; $display("FAIL reset_stream got=%b exp=0", {bus.out_valid, bus.out_sof, bus.out_data});
        end
        checks++;
        if ({bus.frame_done, bus.frame_ok, bus.frame_len, bus.status} !== 18'd0) begin
            failures++; $display("FAIL reset_status got=%b exp=0", {bus.frame_done, bus.frame_ok, bus.frame_len, bus.status});
        end
        rstn = 1'b1;
        idle(2);
    endtask

    task automatic test_nominal();
        int bad, sof_bad;
        logic [4:0] exp_st;
        exp_st = {FCS_BIT, 4'b0000};
        fill_default(); clear_mon();
        send_frame(15, 64, 1'b0, -1); idle(4);
        checks++;
        if (got_data.size() !== 64) begin failures++; $display("FAIL nominal_count got=%0d exp=64", got_data.size()); end
        bad = 0; sof_bad = 0;
        foreach (got_data[i]) begin
            if (got_data[i] !== tx_mem[i]) bad++;
            if (got_sof[i] !== (i == 0)) sof_bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL nominal_data bad_bytes=%0d exp=0", bad); end
        checks++;
        if (sof_bad != 0) begin failures++; $display("FAIL nominal_sof bad_flags=%0d exp=0", sof_bad); end
        checks++;
        if (done_len.size() !== 1) begin
            failures++; $display("FAIL nominal_done got=%0d exp=1", done_len.size());
        end else begin
            checks++;
            if (done_len[0] !== 11'd64) begin failures++; $display("FAIL nominal_len got=%0d exp=64", done_len[0]); end
            checks++;
            if (done_st[0] !== exp_st) begin failures++; $display("FAIL nominal_status got=%b exp=%b", done_st[0], exp_st); end
            checks++;
            if (done_ok[0] !== ~|exp_st) begin failures++; $display("FAIL nominal_ok got=%b exp=%b", done_ok[0], ~|exp_st); end
        end
    endtask

    task automatic test_bad_preamble();
        fill_default(); clear_mon();
        send_frame(1, 10, 1'b0, -1); idle(4);
        checks++;
        if (got_data.size() !== 0 || done_len.size() !== 0) begin
            failures++; $display("FAIL short_preamble bytes=%0d dones=%0d exp=0/0", got_data.size(), done_len.size());
        end
        clear_mon();
        drive(1'b1, 4'h5, 1'b0); drive(1'b1, 4'h5, 1'b0); drive(1'b1, 4'h3, 1'b0);
        drive(1'b1, SFD_NIB, 1'b0);
        for (int b = 0; b < 8; b++) drive(1'b1, tx_mem[b][3:0], 1'b0);
        idle(4);
        checks++;
        if (got_data.size() !== 0 || done_len.size() !== 0) begin
            failures++; $display("FAIL bad_preamble bytes=%0d dones=%0d exp=0/0", got_data.size(), done_len.size());
        end
    endtask

    task automatic test_odd_nibble();
        fill_default(); clear_mon();
        send_frame(2, 64, 1'b1, -1); idle(4);
        checks++;
        if (got_data.size() !== 64) begin failures++; $display("FAIL odd_count got=%0d exp=64", got_data.size()); end
        checks++;
        if (done_len.size() !== 1) begin
            failures++; $display("FAIL odd_done got=%0d exp=1", done_len.size());
        end else if (done_len[0] !== 11'd64 || done_st[0] !== 5'b00001 || done_ok[0] !== 1'b0) begin
            failures++; $display("FAIL odd_result len=%0d status=%b ok=%b exp=64/00001/0", done_len[0], done_st[0], done_ok[0]);
        end
    endtask

    task automatic test_rx_err();
        int bad;
        logic [4:0] exp_st;
        exp_st = {FCS_BIT, 4'b0010};
        fill_default(); clear_mon();
        send_frame(7, 100, 1'b0, 10); idle(4);
        bad = 0;
        foreach (got_data[i]) if (got_data[i] !== tx_mem[i]) bad++;
        checks++;
        if (got_data.size() !== 100 || bad != 0) begin
            failures++; $display("FAIL rx_err_bytes count=%0d bad=%0d exp=100/0", got_data.size(), bad);
        end
        checks++;
        if (done_len.size() !== 1) begin
            failures++; $display("FAIL rx_err_done got=%0d exp=1", done_len.size());
        end else if (done_len[0] !== 11'd100 || done_st[0] !== exp_st || done_ok[0] !== 1'b0) begin
            failures++; $display("FAIL rx_err_result len=%0d status=%b ok=%b exp=100/%b/0", done_len[0], done_st[0], done_ok[0], exp_st);
        end
    endtask

    task automatic test_runt();
        logic [4:0] exp_st;
        exp_st = {FCS_BIT, 4'b1000};
        fill_default(); clear_mon();
        send_frame(7, 20, 1'b0, -1); idle(3);
        send_frame(7, 0, 1'b0, -1); idle(4);
        checks++;
        if (got_data.size() !== 20) begin failures++; $display("FAIL runt_count got=%0d exp=20", got_data.size()); end
        checks++;
        if (done_len.size() !== 2) begin
            failures++; $display("FAIL runt_done got=%0d exp=2", done_len.size());
        end else begin
            checks++;
            if (done_len[0] !== 11'd20 || done_st[0] !== exp_st || done_ok[0] !== 1'b0) begin
                failures++; $display("FAIL runt20_result len=%0d status=%b ok=%b exp=20/%b/0", done_len[0], done_st[0], done_ok[0], exp_st);
            end
            checks++;
            if (done_len[1] !== 11'd0 || done_st[1] !== exp_st) begin
                failures++; $display("FAIL runt0_result len=%0d status=%b exp=0/%b", done_len[1], done_st[1], exp_st);
            end
        end
    endtask

    task automatic test_overlength();
        int bad;
        logic [4:0] exp_st;
        exp_st = {FCS_BIT, 4'b0100};
        fill_default(); clear_mon();
        send_frame(7, 1600, 1'b0, -1); idle(4);
        bad = 0;
        foreach (got_data[i]) if (got_data[i] !== tx_mem[i]) bad++;
        checks++;
        if (got_data.size() !== 1518 || bad != 0) begin
            failures++; $display("FAIL overlength_bytes count=%0d bad=%0d exp=1518/0", got_data.size(), bad);
        end
        checks++;
        if (done_len.size() !== 1) begin
            failures++; $display("FAIL overlength_done got=%0d exp=1", done_len.size());
        end else if (done_len[0] !== 11'd1519 || done_st[0] !== exp_st || done_ok[0] !== 1'b0) begin
            failures++; $display("FAIL overlength_result len=%0d status=%b ok=%b exp=1519/%b/0", done_len[0], done_st[0], done_ok[0], exp_st);
        end
    endtask

    task automatic test_reset_midframe();
        fill_default(); clear_mon();
        repeat (8) drive(1'b1, PREAMBLE_NIB, 1'b0);
        drive(1'b1, SFD_NIB, 1'b0);
        for (int b = 0; b < 700; b++) begin
            drive(1'b1, tx_mem[b][3:0], 1'b0);
            drive(1'b1, tx_mem[b][7:4], 1'b0);
        end
        @(negedge clk);
        rstn = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.out_sof, bus.out_data, bus.frame_done, bus.frame_len, bus.status} !== 27'd0) begin
            failures++; $display("FAIL reset_mid_outputs valid=%b len=%0d exp=0/0", bus.out_valid, bus.frame_len);
        end
        clear_mon();
        for (int b = 700; b < 702; b++) begin
            drive(1'b1, tx_mem[b][3:0], 1'b0);
            drive(1'b1, tx_mem[b][7:4], 1'b0);
        end
        @(negedge clk);
        rstn = 1'b1; bus.rx_dv = 1'b1; bus.rxd = tx_mem[702][3:0]; bus.rx_err = 1'b0;
        drive(1'b1, tx_mem[702][7:4], 1'b0);
        for (int b = 703; b < 750; b++) begin
            drive(1'b1, tx_mem[b][3:0], 1'b0);
            drive(1'b1, tx_mem[b][7:4], 1'b0);
        end
        idle(4);
        checks++;
        if (got_data.size() !== 0 || done_len.size() !== 0) begin
            failures++; $display("FAIL reset_mid_tail bytes=%0d dones=%0d exp=0/0", got_data.size(), done_len.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] st_a, st_b;
        st_a = {FCS_BIT, 4'b1000};
        st_b = {FCS_BIT, 4'b0000};
        fill_default(); clear_mon();
        send_frame(4, 20, 1'b0, -1);
        send_frame(4, 64, 1'b0, -1);
        idle(10);
        checks++;
        if (got_data.size() !== 84) begin failures++; $display("FAIL b2b_count got=%0d exp=84", got_data.size()); end
        checks++;
        if (done_len.size() !== 2) begin
            failures++; $display("FAIL b2b_done got=%0d exp=2", done_len.size());
        end else if (done_len[0] !== 11'd20 || done_st[0] !== st_a || done_len[1] !== 11'd64 || done_st[1] !== st_b) begin
            failures++; $display("FAIL b2b_result len=%0d/%0d status=%b/%b exp=20/64 %b/%b", done_len[0], done_len[1], done_st[0], done_st[1], st_a, st_b);
        end
        checks++;
        if (bus.frame_len !== 11'd64) begin failures++; $display("FAIL b2b_len_hold got=%0d exp=64", bus.frame_len); end
    endtask

`ifdef MII_RX_FCS_CHECK_EN
    task automatic test_fcs();
        logic [31:0] c;
        for (int i = 0; i < 60; i++) tx_mem[i] = 8'(i * 7 + 3);
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 60; i++) begin
            c = c ^ {24'd0, tx_mem[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) tx_mem[60 + k] = c[8*k +: 8];
        clear_mon();
        send_frame(7, 64, 1'b0, -1); idle(4);
        checks++;
        if (done_st.size() !== 1) begin
            failures++; $display("FAIL fcs_good_done got=%0d exp=1", done_st.size());
        end else if (done_st[0] !== 5'b00000 || done_ok[0] !== 1'b1) begin
            failures++; $display("FAIL fcs_good status=%b ok=%b exp=00000/1", done_st[0], done_ok[0]);
        end
        tx_mem[5] = tx_mem[5] ^ 8'h01;
        clear_mon();
        send_frame(7, 64, 1'b0, -1); idle(4);
        checks++;
        if (done_st.size() !== 1) begin
            failures++; $display("FAIL fcs_bad_done got=%0d exp=1", done_st.size());
        end else if (done_st[0] !== 5'b10000 || done_ok[0] !== 1'b0) begin
            failures++; $display("FAIL fcs_bad status=%b ok=%b exp=10000/0", done_st[0], done_ok[0]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_bad_preamble();
        test_odd_nibble();
        test_rx_err();
        test_runt();
        test_overlength();
        test_back_to_back();
`ifdef MII_RX_FCS_CHECK_EN
        test_fcs();
`endif
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
